// File: rtl/c2n_weighted_service_scheduler.sv
// Weighted round-robin scheduler multiplexing NUM_CHANNELS core-to-network
// service message sources onto one service virtual-network injection port.
//
// Ports:
//   clk, reset (async active-low)
//   c2n_message_out / _valid / c2n_destination_valid : per-channel enqueue
//   c2n_network_available : per-channel registered "may enqueue"
//   channel_weight        : per-channel burst budget (0 behaves as 1)
//   network_available     : downstream accepts message_out this cycle
//   message_out / message_out_valid / destination_valid : registered output stage
//   overflow              : sticky per-channel "write hit a full buffer"
//
// Optional feature: define C2N_SCHED_URGENT_EN to make channel 0 a strict
// priority channel that pre-empts the rotation without disturbing its state.

`ifndef TILE_COUNT
`define TILE_COUNT 4
`endif

package c2n_sched_pkg;
   localparam int unsigned TILE_COUNT = `TILE_COUNT;

   typedef struct packed {
      logic [3:0]  kind;
      logic [11:0] payload;
   } service_message_t;

   typedef logic [TILE_COUNT-1:0] tile_mask_t;

   typedef struct packed {
      service_message_t msg;
      tile_mask_t       mask;
   } sched_entry_t;
endpackage

module c2n_weighted_service_scheduler
   import c2n_sched_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS          = 3,
   parameter int unsigned CH_IDX_W              = $clog2(NUM_CHANNELS),
   parameter int unsigned FIFO_DEPTH            = 4,
   parameter int unsigned ALMOST_FULL_THRESHOLD = 2,
   parameter int unsigned WEIGHT_WIDTH          = 3
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  service_message_t [NUM_CHANNELS-1:0]       c2n_message_out,
   input  logic [NUM_CHANNELS-1:0]                   c2n_message_out_valid,
   input  tile_mask_t [NUM_CHANNELS-1:0]             c2n_destination_valid,
   output logic [NUM_CHANNELS-1:0]                   c2n_network_available,
   input  logic [NUM_CHANNELS-1:0][WEIGHT_WIDTH-1:0] channel_weight,
   input  logic                                      network_available,
   output service_message_t                          message_out,
   output logic                                      message_out_valid,
   output tile_mask_t                                destination_valid,
   output logic [NUM_CHANNELS-1:0]                   overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   sched_entry_t             mem       [NUM_CHANNELS][FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr    [NUM_CHANNELS];
   logic [PTR_W-1:0]         rd_ptr    [NUM_CHANNELS];
   logic [CNT_W-1:0]         count     [NUM_CHANNELS];
   logic [CNT_W-1:0]         count_nxt [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]  empty, full, enq, deq;

   logic [CH_IDX_W-1:0]      cur_ch, grant_ch;
   logic [WEIGHT_WIDTH-1:0]  burst_cnt, burst_lim;
   logic                     grant_vld, rotate, urgent, found, stage_free;
   sched_entry_t             head;
   int unsigned              idx;

   // Per-channel buffer status and accepted writes
   always_comb begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
         empty[ch] = (count[ch] == '0);
         full[ch]  = (count[ch] == CNT_W'(FIFO_DEPTH));
         enq[ch]   = c2n_message_out_valid[ch] && !full[ch];
      end
   end

   assign stage_free = !message_out_valid || network_available;

   // Weighted round-robin grant
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = cur_ch;
      rotate    = 1'b0;
      urgent    = 1'b0;
      found     = 1'b0;
      idx       = 0;
      if (stage_free && (|(~empty))) begin
         grant_vld = 1'b1;
`ifdef C2N_SCHED_URGENT_EN
         urgent = !empty[0];
`endif
         if (urgent) begin
            grant_ch = '0;
         end else if (!empty[cur_ch] && (burst_cnt < burst_lim)) begin
            grant_ch = cur_ch;
         end else begin
            rotate = 1'b1;
            for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
               idx = 32'(cur_ch) + i;
               if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
               if (!found && !empty[CH_IDX_W'(idx)]) begin
                  found    = 1'b1;
                  grant_ch = CH_IDX_W'(idx);
               end
            end
         end
      end
   end

   // Dequeue strobes and next occupancy
   always_comb begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
         deq[ch]       = grant_vld && (grant_ch == CH_IDX_W'(ch));
         count_nxt[ch] = count[ch];
         if (enq[ch] && !deq[ch])      count_nxt[ch] = count[ch] + CNT_W'(1);
         else if (!enq[ch] && deq[ch]) count_nxt[ch] = count[ch] - CNT_W'(1);
      end
   end

   assign head = mem[grant_ch][rd_ptr[grant_ch]];

   // Buffer storage (data needs no reset; pointers/counts define validity)
   always_ff @(posedge clk) begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (enq[ch]) mem[ch][wr_ptr[ch]] <= {c2n_message_out[ch], c2n_destination_valid[ch]};
      end
   end

   // Buffer pointers, occupancy, availability and sticky overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            wr_ptr[ch] <= '0;
            rd_ptr[ch] <= '0;
            count[ch]  <= '0;
         end
         c2n_network_available <= '1;
         overflow              <= '0;
      end else begin
         for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (enq[ch]) wr_ptr[ch] <= wr_ptr[ch] + PTR_W'(1);
            if (deq[ch]) rd_ptr[ch] <= rd_ptr[ch] + PTR_W'(1);
            count[ch] <= count_nxt[ch];
            c2n_network_available[ch] <= (count_nxt[ch] < CNT_W'(ALMOST_FULL_THRESHOLD));
            if (c2n_message_out_valid[ch] && full[ch]) overflow[ch] <= 1'b1;
         end
      end
   end

   // Rotation state; an urgent grant leaves it alone so the burst resumes.
   // burst_lim latches the weight at rotation time; reset value 0 forces an
   // immediate rotation so channel 0 is considered first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_ch    <= CH_IDX_W'(NUM_CHANNELS - 1);
         burst_cnt <= '0;
         burst_lim <= '0;
      end else if (grant_vld && !urgent) begin
         if (rotate) begin
            cur_ch    <= grant_ch;
            burst_cnt <= WEIGHT_WIDTH'(1);
            burst_lim <= (channel_weight[grant_ch] == '0) ? WEIGHT_WIDTH'(1)
                                                          : channel_weight[grant_ch];
         end else begin
            burst_cnt <= burst_cnt + WEIGHT_WIDTH'(1);
         end
      end
   end

   // Registered output stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         message_out_valid <= 1'b0;
         message_out       <= '0;
         destination_valid <= '0;
      end else if (stage_free) begin
         message_out_valid <= grant_vld;
         if (grant_vld) begin
            message_out       <= head.msg;
            destination_valid <= head.mask;
         end
      end
   end

endmodule
